core_scheduler: RTL and testbench

Per-core sequencer that drives the `core_state` bus consumed by the thread register file, ALU, LSU and PC units. It walks each instruction through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE and owns the program counter. It handshakes with the instruction fetcher and the LSUs, and reports completion and timeout status to the engine dispatcher.

---
 rtl/core_pkg.sv | 34 +++
 rtl/wait_timer.sv | 42 ++++
 rtl/core_scheduler.sv | 130 +++++++++++++
 tb/tb_core_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the core pipeline blocks (scheduler, register file,
// decoder). Holds the core_state encoding driven on the core_state bus and
// the register-file input mux selector codes.
package core_pkg;

  localparam int STATE_BITS = 3;

  // REQUEST and UPDATE codes are decoded directly by the register file,
  // so the encoding must not be reordered.
  typedef enum logic [STATE_BITS-1:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } core_state_t;

  // Register-file write-back source select, produced by the decoder.
  typedef enum logic [1:0] {
    REG_ARITHMETIC = 2'b00,
    REG_MEMORY     = 2'b01,
    REG_CONSTANT   = 2'b10
  } reg_input_mux_t;

  // An instruction touches memory if it is either a load or a store.
  function automatic logic is_mem_op(input logic rd_en, input logic wr_en);
    return rd_en | wr_en;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer
// Counts cycles spent waiting on the LSUs and flags the cycle in which the
// count reaches LIMIT.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-low
//   clear     in   zero the count (takes priority over count_en)
//   count_en  in   advance the count by one this cycle
//   expired   out  this counted cycle is the LIMIT-th since the last clear
module wait_timer
  import core_pkg::*;
#(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en && count_reg != TOP) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // count_reg holds the number of cycles already spent, so the current
  // cycle is the LIMIT-th one when count_reg == LIMIT-1.
  assign expired = count_en && (count_reg == LAST);

endmodule

// File: rtl/core_scheduler.sv
// core_scheduler
// Per-core sequencer. Steps each instruction through
// FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE, owns the program
// counter, handshakes with the fetcher and the LSUs, and reports completion
// and WAIT timeouts.
// Ports:
//   clk, reset                  clock / synchronous active-low reset
//   start                       level, launches the kernel from IDLE
//   instr_req, instr_addr       fetch request and address (= current_pc)
//   instr_valid                 fetch completion pulse
//   decoded_mem_read_enable     current instruction is a load
//   decoded_mem_write_enable    current instruction is a store
//   decoded_ret                 current instruction is RET
//   lsu_done                    all enabled LSUs finished
//   next_pc                     branch-resolved next PC, used in UPDATE
//   core_state                  state code bus
//   current_pc                  PC of the instruction in flight
//   done, error                 kernel finished / WAIT timeout abort
//   retired_count               saturating count of retired instructions
module core_scheduler
  import core_pkg::*;
#(
  parameter int PC_BITS      = 8,
  parameter int WAIT_TIMEOUT = 255,
  parameter int RETIRE_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   instr_req,
  output logic [PC_BITS-1:0]     instr_addr,
  input  logic                   instr_valid,
  input  logic                   decoded_mem_read_enable,
  input  logic                   decoded_mem_write_enable,
  input  logic                   decoded_ret,
  input  logic                   lsu_done,
  input  logic [PC_BITS-1:0]     next_pc,
  output logic [2:0]             core_state,
  output logic [PC_BITS-1:0]     current_pc,
  output logic                   done,
  output logic                   error,
  output logic [RETIRE_BITS-1:0] retired_count
);

  core_state_t            state_reg;
  logic [PC_BITS-1:0]     pc_reg;
  logic                   instr_req_reg;
  logic                   done_reg;
  logic                   error_reg;
  logic [RETIRE_BITS-1:0] retired_reg;
  logic                   wait_expired;

  // The timer is held clear outside WAIT, so it always starts from zero on
  // WAIT entry and counts every WAIT cycle.
  wait_timer #(
    .LIMIT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg != S_WAIT),
    .count_en (state_reg == S_WAIT),
    .expired  (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      instr_req_reg <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      retired_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_FETCH;
            instr_req_reg <= 1'b1;
          end
        end
        S_FETCH: begin
          if (instr_valid) begin
            state_reg     <= S_DECODE;
            instr_req_reg <= 1'b0;
          end
        end
        S_DECODE:  state_reg <= S_REQUEST;
        S_REQUEST: state_reg <= S_WAIT;
        S_WAIT: begin
          // Non-memory ops pass through in one cycle; for memory ops a
          // same-cycle lsu_done beats the timeout.
          if (!is_mem_op(decoded_mem_read_enable, decoded_mem_write_enable)) begin
            state_reg <= S_EXECUTE;
          end else if (lsu_done) begin
            state_reg <= S_EXECUTE;
          end else if (wait_expired) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
            error_reg <= 1'b1;
          end
        end
        S_EXECUTE: state_reg <= S_UPDATE;
        S_UPDATE: begin
          if (retired_reg != '1) begin
            retired_reg <= retired_reg + 1'b1;
          end
          if (decoded_ret) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            pc_reg        <= next_pc;
            state_reg     <= S_FETCH;
            instr_req_reg <= 1'b1;
          end
        end
        S_DONE: state_reg <= S_DONE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign core_state    = state_reg;
  assign current_pc    = pc_reg;
  assign instr_addr    = pc_reg;
  assign instr_req     = instr_req_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign retired_count = retired_reg;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler. Two instances share every input:
// dut_a uses default parameters, dut_b uses WAIT_TIMEOUT=3, RETIRE_BITS=2
// so the timeout and saturation cases can be observed on it.
module tb_core_scheduler;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_REQUEST = 3;
  localparam int ST_WAIT = 4, ST_EXECUTE = 5, ST_UPDATE = 6, ST_DONE = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       instr_valid = 1'b0;
  logic       mem_rd = 1'b0;
  logic       mem_wr = 1'b0;
  logic       ret = 1'b0;
  logic       lsu_done = 1'b0;
  logic [7:0] next_pc = 8'h00;

  logic       req_a, req_b, done_a, done_b, err_a, err_b;
  logic [7:0] addr_a, addr_b, pc_a, pc_b;
  logic [2:0] state_a, state_b;
  logic [15:0] ret_a;
  logic [1:0]  ret_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start),
    .instr_req(req_a), .instr_addr(addr_a), .instr_valid(instr_valid),
    .decoded_mem_read_enable(mem_rd), .decoded_mem_write_enable(mem_wr),
    .decoded_ret(ret), .lsu_done(lsu_done), .next_pc(next_pc),
    .core_state(state_a), .current_pc(pc_a), .done(done_a), .error(err_a),
    .retired_count(ret_a)
  );

  core_scheduler #(.WAIT_TIMEOUT(3), .RETIRE_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .instr_req(req_b), .instr_addr(addr_b), .instr_valid(instr_valid),
    .decoded_mem_read_enable(mem_rd), .decoded_mem_write_enable(mem_wr),
    .decoded_ret(ret), .lsu_done(lsu_done), .next_pc(next_pc),
    .core_state(state_b), .current_pc(pc_b), .done(done_b), .error(err_b),
    .retired_count(ret_b)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int st(input int sel);
    return (sel != 0) ? int'(state_b) : int'(state_a);
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; instr_valid = 1'b0; lsu_done = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; ret = 1'b0; next_pc = 8'h00;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs one instruction from a FETCH cycle of the watched instance.
  // total counts cycles from this FETCH through the next FETCH (or DONE).
  // lsu_done is raised during WAIT cycle number done_at (0 = never).
  task automatic run_instr(input logic rd, input logic wr, input logic rt,
                           input int done_at, input logic [7:0] npc,
                           input int sel, output int total, output int waits);
    int s;
    bit ended;
    total = 1; waits = 0; ended = 0;
    mem_rd = rd; mem_wr = wr; ret = rt; next_pc = npc;
    instr_valid = 1'b1;
    for (int k = 0; k < 600; k++) begin
      step();
      total++;
      instr_valid = 1'b0;
      lsu_done = 1'b0;
      s = st(sel);
      if (s == ST_WAIT) begin
        waits++;
        lsu_done = (waits == done_at);
      end
      if (s == ST_FETCH || s == ST_DONE) begin
        ended = 1;
        break;
      end
    end
    lsu_done = 1'b0;
    if (!ended) check_eq("run_bound_expired", 0, 1);
  endtask

  initial begin
    int seq [7] = '{ST_FETCH, ST_DECODE, ST_REQUEST, ST_WAIT, ST_EXECUTE, ST_UPDATE, ST_FETCH};
    int total, waits;

    // Reset state
    do_reset();
    reset = 1'b0;
    check_eq("rst_state", state_a, ST_IDLE);
    check_eq("rst_pc", pc_a, 0);
    check_eq("rst_req", req_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_err", err_a, 0);
    check_eq("rst_retired", ret_a, 0);
    reset = 1'b1;

    // Non-memory instruction, state sequence, next_pc = 0x05
    launch();
    check_eq("t1_state0", state_a, seq[0]);
    check_eq("t1_req_fetch", req_a, 1);
    next_pc = 8'h05;
    instr_valid = 1'b1;
    for (int i = 1; i < 7; i++) begin
      step();
      instr_valid = 1'b0;
      check_eq($sformatf("t1_state%0d", i), state_a, seq[i]);
      if (i == 1) check_eq("t1_req_drop", req_a, 0);
    end
    check_eq("t1_pc", pc_a, 8'h05);
    check_eq("t1_addr", addr_a, 8'h05);
    check_eq("t1_retired", ret_a, 1);
    check_eq("t1_req_again", req_a, 1);

    // LDR with lsu_done in WAIT cycle 4
    run_instr(1'b1, 1'b0, 1'b0, 4, 8'h12, 0, total, waits);
    check_eq("ldr_waits", waits, 4);
    check_eq("ldr_cycles", total, 10);
    check_eq("ldr_state", state_a, ST_FETCH);
    check_eq("ldr_pc", pc_a, 8'h12);
    check_eq("ldr_retired", ret_a, 2);
    check_eq("ldr_b_timeout_state", state_b, ST_DONE);
    check_eq("ldr_b_timeout_err", err_b, 1);
    check_eq("ldr_a_err", err_a, 0);

    // RET, then start toggling is ignored
    run_instr(1'b0, 1'b0, 1'b1, 0, 8'hAA, 0, total, waits);
    check_eq("ret_cycles", total, 7);
    check_eq("ret_state", state_a, ST_DONE);
    check_eq("ret_done", done_a, 1);
    check_eq("ret_err", err_a, 0);
    check_eq("ret_pc", pc_a, 8'h12);
    check_eq("ret_retired", ret_a, 3);
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      step();
    end
    start = 1'b0;
    check_eq("ret_hold_state", state_a, ST_DONE);
    check_eq("ret_hold_done", done_a, 1);
    check_eq("ret_hold_pc", pc_a, 8'h12);
    check_eq("ret_hold_req", req_a, 0);

    // STR, WAIT_TIMEOUT=3, lsu_done never
    do_reset();
    launch();
    run_instr(1'b0, 1'b1, 1'b0, 0, 8'h30, 1, total, waits);
    check_eq("to_waits", waits, 3);
    check_eq("to_state", state_b, ST_DONE);
    check_eq("to_err", err_b, 1);
    check_eq("to_done", done_b, 1);
    check_eq("to_retired", ret_b, 0);

    // STR, lsu_done on WAIT cycle 3 coincides with expiry: lsu_done wins
    do_reset();
    launch();
    run_instr(1'b0, 1'b1, 1'b0, 3, 8'h20, 1, total, waits);
    check_eq("race_waits", waits, 3);
    check_eq("race_cycles", total, 9);
    check_eq("race_state", state_b, ST_FETCH);
    check_eq("race_err", err_b, 0);
    check_eq("race_pc", pc_b, 8'h20);

    // Reset during FETCH, then a stray instr_valid in IDLE
    do_reset();
    launch();
    check_eq("mid_req_before", req_a, 1);
    reset = 1'b0;
    step();
    check_eq("mid_state", state_a, ST_IDLE);
    check_eq("mid_req", req_a, 0);
    reset = 1'b1;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    check_eq("mid_idle_state", state_a, ST_IDLE);
    check_eq("mid_idle_req", req_a, 0);
    check_eq("mid_idle_pc", pc_a, 0);
    check_eq("mid_idle_done", done_a, 0);
    check_eq("mid_idle_err", err_a, 0);
    check_eq("mid_idle_retired", ret_a, 0);

    // Five instructions: dut_b's 2-bit counter saturates at 3
    do_reset();
    launch();
    for (int i = 0; i < 5; i++) begin
      run_instr(1'b0, 1'b0, 1'b0, 0, 8'(i + 1), 0, total, waits);
    end
    check_eq("sat_retired_b", ret_b, 3);
    check_eq("sat_retired_a", ret_a, 5);
    check_eq("sat_pc", pc_a, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
